pipe_id_scoreboard: RTL and testbench

PIPE_ID_SCOREBOARD -- requirements
Module: pipe_id_scoreboard

---
 rtl/pipe_id_scoreboard.sv | 79 +++++++
 tb/tb_pipe_id_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_id_scoreboard.sv
// ID-stage register scoreboard: one latency counter per architectural register.
// Detects RAW and WAW hazards for the instruction in ID, stalls the front end,
// and counts stall cycles.
module pipe_id_scoreboard #(
   parameter int REG_AW = 5,
   parameter int LAT_W  = 3,
   parameter int PC_W   = 16
) (
   input  logic              mem_clock,
   input  logic              resetn,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wreg,
   input  logic [REG_AW-1:0] id_wn,
   input  logic [LAT_W-1:0]  id_lat,
   input  logic              flush,
   output logic              wpcir,
   output logic              ID_bubble,
   output logic              issue,
   output logic              pending_any,
   output logic [PC_W-1:0]   stall_count
);

   localparam int NREG = 2 ** REG_AW;

   // cycles remaining until each register's in-flight result is forwardable
   logic [LAT_W-1:0] cnt [NREG];

   logic raw, waw, stall, load_en;

   // hazard detection; slot 0 is held at zero so r0 never raises a hazard
   always_comb begin
      raw = (id_use_rs && (cnt[id_rs] != '0)) ||
            (id_use_rt && (cnt[id_rt] != '0));
      // a younger write must not finish before an older one to the same register
      waw = id_wreg && (id_wn != '0) && (cnt[id_wn] > id_lat);
      stall   = id_valid && !flush && (raw || waw);
      issue   = id_valid && !flush && !stall;
      load_en = issue && id_wreg && (id_wn != '0);
   end

   assign wpcir     = ~stall;
   assign ID_bubble = issue;

   // per-register countdown; an issuing write reloads its destination
   always_ff @(posedge mem_clock or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (r == 0)
               cnt[r] <= '0;
            else if (load_en && (id_wn == REG_AW'(r)))
               cnt[r] <= id_lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

   // any result still in flight, from registered state only
   always_comb begin
      pending_any = 1'b0;
      for (int r = 1; r < NREG; r++)
         if (cnt[r] != '0) pending_any = 1'b1;
   end

   // saturating stall-cycle performance counter
   always_ff @(posedge mem_clock or negedge resetn) begin
      if (!resetn)
         stall_count <= '0;
      else if (stall && (stall_count != '1))
         stall_count <= stall_count + PC_W'(1);
   end

endmodule

// File: tb/tb_pipe_id_scoreboard.sv
// Directed bench for pipe_id_scoreboard with hand-computed expectations.
module tb_pipe_id_scoreboard;

   localparam int REG_AW = 5;
   localparam int LAT_W  = 3;
   localparam int PC_W   = 4;   // small so saturation is reachable

   logic              mem_clock = 1'b0;
   logic              resetn;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs, id_rt, id_wn;
   logic              id_use_rs, id_use_rt, id_wreg;
   logic [LAT_W-1:0]  id_lat;
   logic              flush;
   logic              wpcir, ID_bubble, issue, pending_any;
   logic [PC_W-1:0]   stall_count;

   int checks = 0;
   int errors = 0;

   pipe_id_scoreboard #(.REG_AW(REG_AW), .LAT_W(LAT_W), .PC_W(PC_W)) dut (
      .mem_clock(mem_clock), .resetn(resetn), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wreg(id_wreg), .id_wn(id_wn), .id_lat(id_lat), .flush(flush),
      .wpcir(wpcir), .ID_bubble(ID_bubble), .issue(issue),
      .pending_any(pending_any), .stall_count(stall_count)
   );

   always #5 mem_clock = ~mem_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // drive an ID-stage instruction, then settle before checking
   task automatic drive(input logic v, input int rs, input logic urs, input int rt,
                        input logic urt, input logic wr, input int wn, input int lat,
                        input logic fl);
      id_valid = v; id_rs = REG_AW'(rs); id_use_rs = urs; id_rt = REG_AW'(rt);
      id_use_rt = urt; id_wreg = wr; id_wn = REG_AW'(wn); id_lat = LAT_W'(lat);
      flush = fl;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic cyc();
      @(posedge mem_clock);
      #1;
   endtask

   // write-only instruction
   task automatic wr_op(input int wn, input int lat);
      drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, wn, lat, 1'b0);
   endtask

   // reader of rs
   task automatic rd_rs(input int rs);
      drive(1'b1, rs, 1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      // reset state, with a valid instruction in ID
      resetn = 1'b0;
      drive(1'b1, 3, 1'b1, 4, 1'b1, 1'b1, 5, 2, 1'b0);
      cyc();
      chk("rst_pending", pending_any, 0);
      chk("rst_wpcir", wpcir, 1);
      chk("rst_issue", issue, 1);
      chk("rst_bubble", ID_bubble, 1);
      chk("rst_scnt", stall_count, 0);
      drive(1'b1, 3, 1'b1, 4, 1'b1, 1'b1, 5, 2, 1'b1);
      chk("rst_issue_flush", issue, 0);
      idle();
      resetn = 1'b1;
      cyc();

      // load-use: one stall
      wr_op(8, 1);
      chk("ld_issue", issue, 1);
      cyc();
      rd_rs(8);
      chk("lu_wpcir", wpcir, 0);
      chk("lu_bubble", ID_bubble, 0);
      chk("lu_issue", issue, 0);
      chk("lu_pending", pending_any, 1);
      cyc();
      chk("lu_issue2", issue, 1);
      chk("lu_wpcir2", wpcir, 1);
      cyc();
      idle();
      chk("lu_scnt", stall_count, 1);
      chk("lu_pending2", pending_any, 0);

      // ALU result: no stall
      wr_op(9, 0);
      chk("alu_issue", issue, 1);
      cyc();
      chk("alu_pending", pending_any, 0);
      drive(1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("alu_use_issue", issue, 1);
      cyc();
      idle();
      chk("alu_scnt", stall_count, 1);

      // multi-cycle latency 4: four stalls
      wr_op(3, 4);
      cyc();
      rd_rs(3);
      for (int i = 0; i < 4; i++) begin
         chk("mc_stall", issue, 0);
         cyc();
      end
      chk("mc_issue", issue, 1);
      cyc();
      idle();
      chk("mc_scnt", stall_count, 5);

      // WAW: pending lat 5, then ALU write to same reg stalls 5 cycles
      wr_op(5, 5);
      cyc();
      wr_op(5, 0);
      for (int i = 0; i < 5; i++) begin
         chk("waw_stall", wpcir, 0);
         cyc();
      end
      chk("waw_issue", issue, 1);
      cyc();
      idle();
      chk("waw_scnt", stall_count, 10);
      chk("waw_pending", pending_any, 0);
      wr_op(5, 5);
      cyc();
      wr_op(5, 5);
      chk("waw_eq_issue", issue, 1);
      cyc();
      wr_op(5, 4);
      chk("waw_gt_stall", issue, 0);
      idle();
      for (int i = 0; i < 5; i++) cyc();
      chk("waw_drain", pending_any, 0);
      chk("waw_scnt2", stall_count, 10);

      // r0 is never tracked
      wr_op(0, 7);
      chk("r0_wr_issue", issue, 1);
      cyc();
      chk("r0_pending", pending_any, 0);
      drive(1'b1, 0, 1'b1, 0, 1'b1, 1'b1, 0, 7, 1'b0);
      chk("r0_rd_issue", issue, 1);
      cyc();
      idle();
      chk("r0_pending2", pending_any, 0);

      // flush during a stall, then reset mid-stall
      wr_op(12, 6);
      cyc();
      rd_rs(12);
      chk("fl_stall", wpcir, 0);
      cyc();
      chk("fl_scnt_a", stall_count, 11);
      drive(1'b1, 12, 1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b1);
      chk("fl_wpcir", wpcir, 1);
      chk("fl_issue", issue, 0);
      chk("fl_bubble", ID_bubble, 0);
      cyc();
      chk("fl_scnt_b", stall_count, 11);
      chk("fl_pending", pending_any, 1);
      rd_rs(12);
      chk("fl_restall", wpcir, 0);
      resetn = 1'b0;
      #1;
      chk("mr_pending", pending_any, 0);
      chk("mr_scnt", stall_count, 0);
      chk("mr_wpcir", wpcir, 1);
      chk("mr_issue", issue, 1);
      resetn = 1'b1;
      #1;
      chk("mr_issue2", issue, 1);
      cyc();
      idle();
      chk("mr_scnt2", stall_count, 0);

      // saturation: three rounds of 7 stalls against a 4-bit counter
      for (int k = 0; k < 3; k++) begin
         wr_op(1, 7);
         cyc();
         rd_rs(1);
         for (int i = 0; i < 7; i++) cyc();
         chk("sat_issue", issue, 1);
         cyc();
         idle();
      end
      chk("sat_scnt", stall_count, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
